// File: rtl/elemwise_pkg.sv
// Shared types and elaboration-time helpers for the elementwise multiply engine.
// Combinational constants only: no latency, no backpressure.
package elemwise_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } elemwise_state_t;

   function automatic int beats_f(input int m, input int n, input int lanes);
      return (m * n + lanes - 1) / lanes;
   endfunction

   // Counter width never drops to zero, even for a single-beat configuration.
   function automatic int cnt_w_f(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/elemwise_mul_lane.sv
// One W x W -> 2W multiplier lane, signed when ELEMWISE_SIGNED_EN is defined; combinational.
// No backpressure: a masked lane (index past the array end) drives zero and no write enable.
module elemwise_mul_lane
   import elemwise_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   input  logic           i_idx_vld,
   output logic [2*W-1:0] o_prod,
   output logic           o_wr_en
);

   logic [2*W-1:0] w_prod;

`ifdef ELEMWISE_SIGNED_EN
   assign w_prod = $signed(i_a) * $signed(i_b);
`else
   assign w_prod = i_a * i_b;
`endif

   assign o_prod  = i_idx_vld ? w_prod : '0;
   assign o_wr_en = i_idx_vld;

endmodule

// File: rtl/elemwise_mul_engine.sv
// M x N elementwise multiplier over LANES shared lanes; result valid BEATS cycles after accept (ELEMWISE_SIGNED_EN selects signed).
// Result held in DONE until out_ready; in_ready only in IDLE or in DONE with out_ready (no bubble).
module elemwise_mul_engine
   import elemwise_pkg::*;
#(
   parameter int W     = 8,
   parameter int N     = 8,
   parameter int M     = 3,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [M*N*W-1:0]   a,
   input  logic [M*N*W-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [M*N*2*W-1:0] result,
   output logic               busy
);

   localparam int TOTAL = M * N;
   localparam int BEATS = beats_f(M, N, LANES);
   localparam int CW    = cnt_w_f(BEATS);
   localparam int KW    = $clog2(BEATS * LANES + 1);

   localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
   localparam logic [KW-1:0] K_TOTAL   = KW'(TOTAL);

   elemwise_state_t          r_state;
   elemwise_state_t          w_state_nxt;
   logic [CW-1:0]            r_beat;
   logic [M*N*W-1:0]         r_a;
   logic [M*N*W-1:0]         r_b;
   logic [M*N*2*W-1:0]       r_result;
   logic                     w_accept;

   logic [KW-1:0]            w_lane_k    [LANES];
   logic                     w_lane_wr   [LANES];
   logic [2*W-1:0]           w_lane_prod [LANES];

   assign w_accept = in_valid && in_ready;
   assign result   = r_result;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = !rst;
            if (w_accept) w_state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (r_beat == BEAT_LAST) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = !rst && out_ready;
            if (w_accept)       w_state_nxt = BUSY;
            else if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_beat <= '0;
         end else if (r_state == BUSY) begin
            r_beat <= r_beat + CW'(1);
         end
      end
   end

   // Lane l on beat j owns element j*LANES+l; indices past the array are clamped to 0 and masked.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [KW-1:0] w_k;
      logic [KW-1:0] w_ksel;
      logic          w_k_vld;

      assign w_k     = KW'(r_beat) * KW'(LANES) + KW'(l);
      assign w_k_vld = w_k < K_TOTAL;
      assign w_ksel  = w_k_vld ? w_k : '0;
      assign w_lane_k[l] = w_ksel;

      elemwise_mul_lane #(.W(W)) u_lane (
         .i_a       (r_a[w_ksel*W +: W]),
         .i_b       (r_b[w_ksel*W +: W]),
         .i_idx_vld (w_k_vld),
         .o_prod    (w_lane_prod[l]),
         .o_wr_en   (w_lane_wr[l])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
      end else if (r_state == BUSY) begin
         for (int l = 0; l < LANES; l++) begin
            if (w_lane_wr[l]) r_result[w_lane_k[l]*(2*W) +: 2*W] <= w_lane_prod[l];
         end
      end
   end

endmodule

// File: tb/tb_elemwise_mul_engine.sv
// Bench for elemwise_mul_engine at LANES=4, 5 and 24; expectations follow ELEMWISE_SIGNED_EN.
module tb_elemwise_mul_engine;

   localparam int W  = 8;
   localparam int N  = 8;
   localparam int M  = 3;
   localparam int E  = M * N;
   localparam int AW = E * W;
   localparam int RW = E * 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] a_in;
   logic [AW-1:0] b_in;
   logic          in_valid  [3];
   logic          in_ready  [3];
   logic          out_valid [3];
   logic          out_ready [3];
   logic          busy      [3];
   logic [RW-1:0] result    [3];

   int bt [3] = '{6, 5, 1};

   typedef struct {
      int            dut;
      logic [RW-1:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int            dut;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [RW-1:0] exp;
   } tv_t;
   tv_t tv[9];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   elemwise_mul_engine #(.W(W), .N(N), .M(M), .LANES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a_in), .b(b_in),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0]));
   elemwise_mul_engine #(.W(W), .N(N), .M(M), .LANES(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a_in), .b(b_in),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1]));
   elemwise_mul_engine #(.W(W), .N(N), .M(M), .LANES(24)) u_dut24 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a_in), .b(b_in),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(result[2]), .busy(busy[2]));

   function automatic logic [RW-1:0] model(input logic [AW-1:0] x, input logic [AW-1:0] y);
      logic [RW-1:0]  r;
      logic [2*W-1:0] xe;
      logic [2*W-1:0] ye;
      r = '0;
      for (int k = 0; k < E; k++) begin
`ifdef ELEMWISE_SIGNED_EN
         xe = {{W{x[k*W+W-1]}}, x[k*W +: W]};
         ye = {{W{y[k*W+W-1]}}, y[k*W +: W]};
`else
         xe = {{W{1'b0}}, x[k*W +: W]};
         ye = {{W{1'b0}}, y[k*W +: W]};
`endif
         r[k*2*W +: 2*W] = xe * ye;
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] pat(input int sel);
      logic [AW-1:0] x;
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++)
            x[(m*N+n)*W +: W] = (sel == 0) ? 8'(n + 1 + 10*m) : 8'((8 - n) + 10*m);
      return x;
   endfunction

   function automatic logic [AW-1:0] rnd();
      logic [AW-1:0] x;
      for (int k = 0; k < E; k++) x[k*W +: W] = 8'($urandom);
      return x;
   endfunction

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Scoreboard check on the cycle before the output handshake edge.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst && out_valid[d] && out_ready[d]) begin
            if (sb_q.size() == 0) begin
               chk_int("unexpected output dut", d, -1);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               chk_int("sb dut", d, e.dut);
               chk_vec("sb result", result[d], e.exp);
            end
         end
      end
   end

   task automatic send(input int d, input logic [AW-1:0] x, input logic [AW-1:0] y);
      int t;
      t = 0;
      a_in = x;
      b_in = y;
      in_valid[d] = 1'b1;
      @(negedge clk);
      while (!in_ready[d] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[d]) begin
         chk_int("send timeout", t, -1);
         in_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      sb_q.push_back('{d, model(x, y)});
      #1;
      in_valid[d] = 1'b0;
      a_in = ~x;
      b_in = ~y;
   endtask

   task automatic wait_valid(input int d, input int beats);
      int lat;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid[d] && lat < 50);
      chk_int("latency", lat, beats);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk_int("drain", sb_q.size(), 0);
   endtask

   task automatic run_one(input int d, input logic [AW-1:0] x, input logic [AW-1:0] y,
                          output logic [RW-1:0] res);
      out_ready[d] = 1'b1;
      send(d, x, y);
      wait_valid(d, bt[d]);
      res = result[d];
      drain();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RW-1:0] res;
      logic [RW-1:0] held;
      logic [AW-1:0] ff_v;
      logic [AW-1:0] m128;
      logic [15:0]   ff_exp;

      ff_v = '1;
      for (int k = 0; k < E; k++) m128[k*W +: W] = 8'h80;
`ifdef ELEMWISE_SIGNED_EN
      ff_exp = 16'h0001;
`else
      ff_exp = 16'hFE01;
`endif

      tv[0] = '{0, pat(0), pat(1), model(pat(0), pat(1))};
      tv[1] = '{0, ff_v, ff_v, model(ff_v, ff_v)};
      tv[2] = '{0, m128, m128, model(m128, m128)};
      tv[3] = '{0, rnd(), rnd(), '0};
      tv[4] = '{0, '0, rnd(), '0};
      tv[5] = '{1, pat(0), pat(1), model(pat(0), pat(1))};
      tv[6] = '{1, rnd(), rnd(), '0};
      tv[7] = '{2, pat(0), pat(1), model(pat(0), pat(1))};
      tv[8] = '{2, ff_v, rnd(), '0};
      for (int i = 3; i < 9; i++) if (i != 5 && i != 7) tv[i].exp = model(tv[i].a, tv[i].b);

      rst = 1'b1;
      a_in = '0;
      b_in = '0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk_bit("reset out_valid", out_valid[d], 1'b0);
         chk_bit("reset busy", busy[d], 1'b0);
         chk_bit("reset in_ready", in_ready[d], 1'b0);
         chk_vec("reset result", result[d], '0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk_bit("idle in_ready", in_ready[d], 1'b1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_one(tv[i].dut, tv[i].a, tv[i].b, res);
         chk_vec("table result", res, tv[i].exp);
         if (i == 0) begin
            chk_int("r00", int'(res[0*16 +: 16]), 8);
            chk_int("r07", int'(res[7*16 +: 16]), 8);
            chk_int("r10", int'(res[8*16 +: 16]), 198);
            chk_int("r27", int'(res[23*16 +: 16]), 588);
         end
         if (i == 1) begin
            chk_int("ff first", int'(res[0 +: 16]), int'(ff_exp));
            chk_int("ff last", int'(res[23*16 +: 16]), int'(ff_exp));
         end
         if (i == 2) chk_int("m128", int'(res[5*16 +: 16]), 16'h4000);
      end

      // Output stall: result and flags hold while out_ready is low.
      out_ready[0] = 1'b0;
      send(0, rnd(), rnd());
      wait_valid(0, 6);
      held = result[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk_bit("stall out_valid", out_valid[0], 1'b1);
         chk_bit("stall in_ready", in_ready[0], 1'b0);
         chk_bit("stall busy", busy[0], 1'b0);
         chk_vec("stall result", result[0], held);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      chk_bit("release out_valid", out_valid[0], 1'b0);
      chk_bit("release in_ready", in_ready[0], 1'b1);
      drain();
      run_one(0, pat(1), pat(0), res);
      chk_vec("after stall", res, model(pat(1), pat(0)));

      // Back-to-back: output handshake and new accept on the same edge.
      out_ready[0] = 1'b0;
      send(0, rnd(), rnd());
      wait_valid(0, 6);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      send(0, pat(0), rnd());
      chk_bit("b2b out_valid", out_valid[0], 1'b0);
      chk_bit("b2b busy", busy[0], 1'b1);
      wait_valid(0, 6);
      drain();

      // Reset during beat 3 aborts the operation immediately.
      out_ready[0] = 1'b1;
      send(0, rnd(), rnd());
      repeat (3) @(posedge clk);
      #1;
      chk_bit("mid busy before", busy[0], 1'b1);
      rst = 1'b1;
      #1;
      chk_bit("abort out_valid", out_valid[0], 1'b0);
      chk_bit("abort busy", busy[0], 1'b0);
      chk_bit("abort in_ready", in_ready[0], 1'b0);
      chk_vec("abort result", result[0], '0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_one(0, pat(0), pat(1), res);
      chk_vec("after abort", res, model(pat(0), pat(1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
